// File: rtl/sort4_frame_ctrl_pkg.sv
// Shared definitions for the four-lane frame sorter: lane count, FSM states
// and the pad-value helper used to fill unused lanes.
package sorter_pkg;

   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned CNT_W     = 3;
   localparam int unsigned MAX_WIDTH = 64;

   typedef enum logic [1:0] {
      FILL,
      SORT,
      HOLD
   } state_t;

   // All-ones in the low 'width' bits; callers cast to their key width.
   function automatic logic [MAX_WIDTH-1:0] pad_fill(input int unsigned width);
      logic [MAX_WIDTH-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
         if (i < width) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/sort4_frame_ctrl_if.sv
// Key-in and sorted-frame-out handshakes of the frame sorter.
interface sort4_frame_ctrl_if #(
   parameter int unsigned WIDTH = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [4*WIDTH-1:0]   out_data;
   logic [2:0]           out_count;
   logic                 busy;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count, busy
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count, busy
   );
endinterface

// File: rtl/sort4_frame_ctrl_net.sv
// Combinational 4-input ascending sorting network, 5 comparators, depth 3.
// Lane 0 (smallest) sits in the low WIDTH bits of both a and d.
module sortingNetwork4 #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [4*WIDTH-1:0] a,
   output logic [4*WIDTH-1:0] d
);

   logic [WIDTH-1:0] w_s0 [4];
   logic [WIDTH-1:0] w_s1 [4];
   logic [WIDTH-1:0] w_s2 [4];
   logic [WIDTH-1:0] w_s3 [4];

   always_comb begin
      for (int unsigned i = 0; i < 4; i++) w_s0[i] = a[i*WIDTH +: WIDTH];

      // stage 1: (0,1) (2,3)
      w_s1[0] = (w_s0[0] <= w_s0[1]) ? w_s0[0] : w_s0[1];
      w_s1[1] = (w_s0[0] <= w_s0[1]) ? w_s0[1] : w_s0[0];
      w_s1[2] = (w_s0[2] <= w_s0[3]) ? w_s0[2] : w_s0[3];
      w_s1[3] = (w_s0[2] <= w_s0[3]) ? w_s0[3] : w_s0[2];

      // stage 2: (0,2) (1,3)
      w_s2[0] = (w_s1[0] <= w_s1[2]) ? w_s1[0] : w_s1[2];
      w_s2[2] = (w_s1[0] <= w_s1[2]) ? w_s1[2] : w_s1[0];
      w_s2[1] = (w_s1[1] <= w_s1[3]) ? w_s1[1] : w_s1[3];
      w_s2[3] = (w_s1[1] <= w_s1[3]) ? w_s1[3] : w_s1[1];

      // stage 3: (1,2)
      w_s3[0] = w_s2[0];
      w_s3[1] = (w_s2[1] <= w_s2[2]) ? w_s2[1] : w_s2[2];
      w_s3[2] = (w_s2[1] <= w_s2[2]) ? w_s2[2] : w_s2[1];
      w_s3[3] = w_s2[3];

      d = '0;
      for (int unsigned i = 0; i < 4; i++) d[i*WIDTH +: WIDTH] = w_s3[i];
   end

endmodule

// File: rtl/sort4_frame_ctrl.sv
// Frame sequencer: collects up to four keys, pads, sorts in one SORT cycle,
// then holds the ascending frame until the downstream handshake.
module sort4_frame_ctrl
   import sorter_pkg::*;
#(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] PAD   = WIDTH'(pad_fill(WIDTH))
) (
   input  logic               clk,
   input  logic               rst,
   sort4_frame_ctrl_if.slave  bus
);

   state_t                 r_state;
   state_t                 w_next;
   logic [CNT_W-1:0]       r_cnt;
   logic [WIDTH-1:0]       r_slot [NUM_LANES];
   logic [4*WIDTH-1:0]     r_out_data;
   logic [CNT_W-1:0]       r_out_count;
   logic [4*WIDTH-1:0]     w_lanes;
   logic [4*WIDTH-1:0]     w_sorted;
   logic                   w_accept;
   logic                   w_release;

   always_comb begin
      w_lanes = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) w_lanes[i*WIDTH +: WIDTH] = r_slot[i];
   end

   sortingNetwork4 #(.WIDTH(WIDTH)) u_net (
      .a (w_lanes),
      .d (w_sorted)
   );

   assign w_accept  = bus.in_valid && (r_state == FILL);
   assign w_release = bus.out_ready && (r_state == HOLD);

   always_comb begin
      w_next        = r_state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      unique case (r_state)
         FILL: begin
            bus.in_ready = 1'b1;
            if (w_accept && (bus.in_last || r_cnt == CNT_W'(NUM_LANES - 1))) w_next = SORT;
         end
         SORT: w_next = HOLD;
         HOLD: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) w_next = FILL;
         end
         default: w_next = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= FILL;
         r_cnt       <= '0;
         r_out_data  <= '0;
         r_out_count <= '0;
         for (int unsigned i = 0; i < NUM_LANES; i++) r_slot[i] <= PAD;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_slot[r_cnt[1:0]] <= bus.in_data;
            r_cnt              <= r_cnt + CNT_W'(1);
         end
         if (r_state == SORT) begin
            r_out_data  <= w_sorted;
            r_out_count <= r_cnt;
         end
         // Pad reload happens on the way back to FILL so the next frame starts clean.
         if (w_release) begin
            r_cnt <= '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) r_slot[i] <= PAD;
         end
      end
   end

   assign bus.out_data  = r_out_data;
   assign bus.out_count = r_out_count;
   assign bus.busy      = (r_state != FILL) || (r_cnt != '0);

endmodule

// File: tb/tb_sort4_frame_ctrl.sv
// Directed bench for sort4_frame_ctrl: latency, padding, backpressure,
// duplicates and mid-frame reset.
module tb_sort4_frame_ctrl;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   sort4_frame_ctrl_if #(.WIDTH(16)) bus ();

   sort4_frame_ctrl #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [15:0] d, input logic l);
      int unsigned n;
      n = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_out();
      int unsigned n;
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
   endtask

   task automatic expect_frame(input string tag, input logic [63:0] data, input logic [2:0] cnt);
      wait_out();
      check({tag, "_data"}, bus.out_data, data);
      check({tag, "_count"}, 64'(bus.out_count), 64'(cnt));
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests         = 0;
      fails         = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready",  64'(bus.in_ready),  64'd1);
      check("rst_busy",      64'(bus.busy),      64'd0);
      check("rst_out_data",  bus.out_data,       64'd0);
      check("rst_out_count", 64'(bus.out_count), 64'd0);
      rst = 1'b0;

      // Frame of four, exact two-cycle latency after the fourth key.
      send(16'h0030, 1'b0);
      send(16'h0010, 1'b0);
      send(16'h0040, 1'b0);
      send(16'h0020, 1'b0);
      @(negedge clk);
      check("f4_sort_valid", 64'(bus.out_valid), 64'd0);
      check("f4_sort_ready", 64'(bus.in_ready),  64'd0);
      check("f4_sort_busy",  64'(bus.busy),      64'd1);
      @(negedge clk);
      check("f4_hold_valid", 64'(bus.out_valid), 64'd1);
      check("f4_data",  bus.out_data, 64'h0040_0030_0020_0010);
      check("f4_count", 64'(bus.out_count), 64'd4);
      @(negedge clk);
      check("f4_after_valid", 64'(bus.out_valid), 64'd0);
      check("f4_after_ready", 64'(bus.in_ready),  64'd1);
      check("f4_after_busy",  64'(bus.busy),      64'd0);

      send(16'h0005, 1'b0);
      send(16'h0003, 1'b1);
      expect_frame("f2", 64'hFFFF_FFFF_0005_0003, 3'd2);

      send(16'h1234, 1'b1);
      expect_frame("f1", 64'hFFFF_FFFF_FFFF_1234, 3'd1);

      // Backpressure with a key waiting at the input the whole time.
      bus.out_ready = 1'b0;
      send(16'h0009, 1'b0);
      send(16'h0001, 1'b1);
      wait_out();
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0002;
      bus.in_last  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", 64'(bus.out_valid), 64'd1);
         check("bp_ready", 64'(bus.in_ready),  64'd0);
         check("bp_data",  bus.out_data, 64'hFFFF_FFFF_0009_0001);
         check("bp_count", 64'(bus.out_count), 64'd2);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_post_ready", 64'(bus.in_ready), 64'd1);
      check("bp_post_busy",  64'(bus.busy),     64'd0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      expect_frame("bp_next", 64'hFFFF_FFFF_FFFF_0002, 3'd1);

      for (int i = 0; i < 4; i++) send(16'h0007, 1'b0);
      expect_frame("dup", 64'h0007_0007_0007_0007, 3'd4);

      // Reset mid-frame, with a key offered during the reset cycle.
      send(16'h0100, 1'b0);
      send(16'h0200, 1'b0);
      send(16'h0300, 1'b0);
      @(negedge clk);
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h00AA;
      @(negedge clk);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      check("mrst_valid", 64'(bus.out_valid), 64'd0);
      check("mrst_busy",  64'(bus.busy),      64'd0);
      check("mrst_ready", 64'(bus.in_ready),  64'd1);
      send(16'h0004, 1'b0);
      send(16'h0003, 1'b0);
      send(16'h0002, 1'b0);
      @(negedge clk);
      check("mrst_no_early_out", 64'(bus.out_valid), 64'd0);
      send(16'h0001, 1'b0);
      expect_frame("mrst", 64'h0004_0003_0002_0001, 3'd4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
